// File: rtl/rs_bank_ctrl_if.sv
// Requester/bank-side bundle for rs_bank_ctrl: request ports, grant pulse,
// SR drive to the flop bank, Q feedback and status.
interface rs_bank_ctrl_if #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = 3
);
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      gnt;
  logic [2*NFF-1:0]     sr_out;
  logic [NFF-1:0]       q_in;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 err_clr;

  modport slave (
    input  req, req_op, req_idx, q_in, err_clr,
    output gnt, sr_out, busy, done, err
  );

  modport master (
    output req, req_op, req_idx, q_in, err_clr,
    input  gnt, sr_out, busy, done, err
  );
endinterface

// File: rtl/rs_bank_ctrl.sv
// Round-robin sequencer that shares a bank of clocked RS flops: grants one
// requester, drives one SR pair for a single cycle, then verifies the flop's Q.
module rs_bank_ctrl #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  rs_bank_ctrl_if.slave bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_CLR = 2'b01,
    OP_SET = 2'b10,
    OP_TGL = 2'b11
  } op_t;

  // Registered state and outputs
  state_t            r_state;
  logic [PTRW-1:0]   r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic [2*NFF-1:0]  r_sr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [IDXW-1:0]   r_idx;
  logic              r_idx_ok;
  logic              r_exp;

  // Next-state values
  state_t            w_state_nxt;
  logic [PTRW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic [2*NFF-1:0]  w_sr_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic [IDXW-1:0]   w_idx_nxt;
  logic              w_idx_ok_nxt;
  logic              w_exp_nxt;

  // Arbitration and decode of the winning request
  logic              w_found;
  logic [PTRW-1:0]   w_win;
  op_t               w_req_op;
  logic [IDXW-1:0]   w_req_idx;
  logic              w_tgt_ok;
  logic              w_tgt_q;
  logic [1:0]        w_code;
  logic              w_exp;
  logic              w_chk_q;

  // Round-robin search: first asserted req at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!w_found && bus.req[PTRW'((int'(r_ptr) + off) % NREQ)]) begin
        w_found = 1'b1;
        w_win   = PTRW'((int'(r_ptr) + off) % NREQ);
      end
    end
  end

  always_comb begin
    w_req_op  = OP_NOP;
    w_req_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PTRW'(k) == w_win) begin
        w_req_op  = op_t'(bus.req_op[2*k +: 2]);
        w_req_idx = bus.req_idx[IDXW*k +: IDXW];
      end
    end
  end

  // Target lookup; an index past the bank leaves w_tgt_ok low.
  always_comb begin
    w_tgt_ok = 1'b0;
    w_tgt_q  = 1'b0;
    for (int i = 0; i < NFF; i++) begin
      if (IDXW'(i) == w_req_idx) begin
        w_tgt_ok = 1'b1;
        w_tgt_q  = bus.q_in[i];
      end
    end
  end

  // Toggle is turned into a plain set or clear here, so 2'b11 never leaves.
  always_comb begin
    w_code = 2'b00;
    w_exp  = w_tgt_q;
    unique case (w_req_op)
      OP_SET: begin w_code = 2'b10; w_exp = 1'b1; end
      OP_CLR: begin w_code = 2'b01; w_exp = 1'b0; end
      OP_TGL: begin w_code = w_tgt_q ? 2'b01 : 2'b10; w_exp = ~w_tgt_q; end
      default: begin w_code = 2'b00; w_exp = w_tgt_q; end
    endcase
  end

  always_comb begin
    w_chk_q = 1'b0;
    for (int i = 0; i < NFF; i++) begin
      if (IDXW'(i) == r_idx) w_chk_q = bus.q_in[i];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_gnt_nxt    = '0;
    w_sr_nxt     = '0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = bus.err_clr ? 1'b0 : r_err;
    w_idx_nxt    = r_idx;
    w_idx_ok_nxt = r_idx_ok;
    w_exp_nxt    = r_exp;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt    = NREQ'(1) << w_win;
          w_ptr_nxt    = PTRW'((int'(w_win) + 1) % NREQ);
          w_idx_nxt    = w_req_idx;
          w_idx_ok_nxt = w_tgt_ok;
          w_exp_nxt    = w_exp;
          for (int i = 0; i < NFF; i++) begin
            if (IDXW'(i) == w_req_idx) w_sr_nxt[2*i +: 2] = w_code;
          end
          w_state_nxt  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_done_nxt  = 1'b1;
        // A new error overrides a same-cycle err_clr.
        if (!r_idx_ok || (w_chk_q != r_exp)) w_err_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // NOTE: every register here is a plain flop, so all of them take an async
  // reset value; there is no memory array that would need to stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_sr     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_idx_ok <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sr     <= w_sr_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_idx    <= w_idx_nxt;
      r_idx_ok <= w_idx_ok_nxt;
      r_exp    <= w_exp_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.sr_out = r_sr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_rs_bank_ctrl.sv
// Directed bench for rs_bank_ctrl with a behavioural RS flop bank that can
// be preloaded and can hold selected Q outputs stuck at 0.
module tb_rs_bank_ctrl;

  localparam int NREQ = 4;
  localparam int NFF  = 8;
  localparam int IDXW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_bank_ctrl_if #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) bus ();

  rs_bank_ctrl #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural bank: samples the SR pairs at each rising edge.
  logic [NFF-1:0] q_bank;
  logic [NFF-1:0] stuck0;
  logic [NFF-1:0] pre_val;
  logic           pre_en;

  always @(posedge clk) begin
    if (pre_en) begin
      q_bank <= pre_val;
    end else begin
      for (int i = 0; i < NFF; i++) begin
        case (bus.sr_out[2*i +: 2])
          2'b10:   q_bank[i] <= 1'b1;
          2'b01:   q_bank[i] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.q_in = q_bank & ~stuck0;

  // Counts any cycle with an illegal 11 code or more than one active pair.
  int n_bad = 0;
  always @(negedge clk) begin
    int nz;
    nz = 0;
    for (int i = 0; i < NFF; i++) begin
      if (bus.sr_out[2*i +: 2] == 2'b11) n_bad++;
      if (bus.sr_out[2*i +: 2] != 2'b00) nz++;
    end
    if (nz > 1) n_bad++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [IDXW-1:0] idx);
    bus.req[k]                  = 1'b1;
    bus.req_op[2*k +: 2]        = op;
    bus.req_idx[IDXW*k +: IDXW] = idx;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.req_op  = '0;
    bus.req_idx = '0;
    bus.err_clr = 1'b0;
    stuck0      = '0;
    pre_en      = 1'b1;
    pre_val     = '0;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({bus.sr_out, bus.gnt, bus.busy, bus.done, bus.err}), 32'h0);
    rst_n  = 1'b1;
    pre_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_quiet", 32'({bus.sr_out, bus.gnt, bus.busy, bus.done, bus.err}), 32'h0);
    end

    // Single set: requester 0, idx 5
    set_req(0, 2'b10, 4'd5);
    @(negedge clk);
    check("set_gnt",  32'(bus.gnt), 32'h1);
    check("set_sr",   32'(bus.sr_out), 32'h0800);
    check("set_busy", 32'(bus.busy), 32'h1);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("set_sr_off", 32'(bus.sr_out), 32'h0);
    check("set_q",      32'(bus.q_in), 32'h20);
    check("set_nodone", 32'(bus.done), 32'h0);
    @(negedge clk);
    check("set_done", 32'({bus.done, bus.busy, bus.err}), 32'b100);

    // Toggle twice on flop 2 (starting from Q=1), back to back
    pre_val = 8'h24;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    check("tgl_pre_q", 32'(bus.q_in), 32'h24);
    set_req(1, 2'b11, 4'd2);
    @(negedge clk);
    check("tgl1_gnt", 32'(bus.gnt), 32'h2);
    check("tgl1_sr",  32'(bus.sr_out), 32'h0010);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("tgl1_q", 32'(bus.q_in), 32'h20);
    @(negedge clk);
    check("tgl1_done", 32'({bus.done, bus.err}), 32'b10);
    set_req(1, 2'b11, 4'd2);
    @(negedge clk);
    check("tgl2_gnt", 32'(bus.gnt), 32'h2);
    check("tgl2_sr",  32'(bus.sr_out), 32'h0020);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("tgl2_q", 32'(bus.q_in), 32'h24);
    @(negedge clk);
    check("tgl2_done", 32'({bus.done, bus.err}), 32'b10);

    // Reset pulse so the round-robin pointer starts at 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all four holding nop requests
    bus.req     = 4'hF;
    bus.req_op  = '0;
    bus.req_idx = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (g % 4);
      @(negedge clk);
      check("rr_gnt",    32'(bus.gnt), 32'(exp_g));
      check("rr_sr",     32'(bus.sr_out), 32'h0);
      if (g == 4) bus.req = '0;
      @(negedge clk);
      check("rr_gnt_off", 32'({bus.gnt, bus.sr_out}), 32'h0);
      @(negedge clk);
      check("rr_done", 32'({bus.done, bus.err, bus.q_in}), 32'({1'b1, 1'b0, 8'h24}));
    end

    // Out-of-range index: requester 2, idx 9
    set_req(2, 2'b10, 4'd9);
    @(negedge clk);
    check("oor_gnt", 32'(bus.gnt), 32'h4);
    check("oor_sr",  32'(bus.sr_out), 32'h0);
    bus.req[2] = 1'b0;
    @(negedge clk);
    check("oor_sr2", 32'(bus.sr_out), 32'h0);
    @(negedge clk);
    check("oor_err", 32'({bus.done, bus.err}), 32'b11);
    bus.err_clr = 1'b1;
    @(negedge clk);
    check("oor_clr", 32'(bus.err), 32'h0);
    bus.err_clr = 1'b0;

    // Q stuck at 0 against a set on flop 6
    stuck0 = 8'h40;
    set_req(3, 2'b10, 4'd6);
    @(negedge clk);
    check("stk_gnt", 32'(bus.gnt), 32'h8);
    check("stk_sr",  32'(bus.sr_out), 32'h2000);
    bus.req[3] = 1'b0;
    @(negedge clk);
    check("stk_q", 32'(bus.q_in), 32'h24);
    @(negedge clk);
    check("stk_err", 32'({bus.done, bus.err}), 32'b11);

    // err_clr held through a second failing command: the new error wins
    bus.err_clr = 1'b1;
    set_req(3, 2'b10, 4'd6);
    @(negedge clk);
    check("pri_cleared", 32'({bus.gnt, bus.err}), 32'({4'h8, 1'b0}));
    bus.req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pri_err_wins", 32'({bus.done, bus.err}), 32'b11);
    @(negedge clk);
    check("pri_clr_after", 32'(bus.err), 32'h0);
    bus.err_clr = 1'b0;
    stuck0      = '0;

    // Reset in the DRIVE cycle with requesters 0 and 1 both holding
    set_req(0, 2'b10, 4'd0);
    set_req(1, 2'b01, 4'd1);
    @(negedge clk);
    check("mid_gnt", 32'(bus.gnt), 32'h1);
    check("mid_sr",  32'(bus.sr_out), 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async", 32'({bus.sr_out, bus.busy, bus.gnt}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_q_kept", 32'(bus.q_in), 32'h64);
    @(negedge clk);
    check("mid_regnt",    32'(bus.gnt), 32'h1);
    check("mid_regnt_sr", 32'(bus.sr_out), 32'h0002);
    bus.req = '0;
    @(negedge clk);
    check("mid_q", 32'(bus.q_in), 32'h65);
    @(negedge clk);
    check("mid_done", 32'({bus.done, bus.err}), 32'b10);

    check("no_illegal_code", 32'(n_bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
